// File: rtl/zap_decode_uop_arbiter_pkg.sv
// Shared decode constants for the micro-op arbiter: FSM state encodings,
// owner IDs and the instruction width carried through the decode stage.
package zap_decode_uop_arbiter_pkg;

  localparam int INSTR_W = 35;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCK_SEQ = 2'd1,
    ST_LOCK_CP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_SEQ = 1'b0,
    OWNER_CP  = 1'b1
  } owner_t;

  function automatic arb_state_t lock_state(input owner_t owner);
    return (owner == OWNER_CP) ? ST_LOCK_CP : ST_LOCK_SEQ;
  endfunction

  function automatic owner_t other_owner(input owner_t owner);
    return (owner == OWNER_CP) ? OWNER_SEQ : OWNER_CP;
  endfunction

endpackage

// File: rtl/zap_rr_arb2.sv
// Two-way round-robin arbiter with a lock override; the pointer names the
// requester that wins the next tie and moves only when a sequence ends.
module zap_rr_arb2
  import zap_decode_uop_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_req,
  input  logic       i_lock,
  input  owner_t     i_lock_owner,
  input  logic       i_update,
  input  owner_t     i_update_owner,
  output logic [1:0] o_grant,
  output owner_t     o_grant_owner
);

  owner_t ptr_q;

  // NOTE: o_grant gets a default before any branch so no path leaves it
  // unassigned; a missing default in always_comb infers a latch.
  always_comb begin
    o_grant = 2'b00;
    if (i_lock) begin
      if (i_lock_owner == OWNER_CP) o_grant = {i_req[1], 1'b0};
      else                          o_grant = {1'b0, i_req[0]};
    end else begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (ptr_q == OWNER_SEQ) ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
    o_grant_owner = o_grant[1] ? OWNER_CP : OWNER_SEQ;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)    ptr_q <= OWNER_SEQ;
    else if (i_update) ptr_q <= other_owner(i_update_owner);
  end

endmodule

// File: rtl/zap_decode_uop_arbiter.sv
// Merges the LDM/STM/SWP sequencer and coprocessor micro-op streams into one
// registered decode output, locking onto a requester for multi-beat sequences.
module zap_decode_uop_arbiter
  import zap_decode_uop_arbiter_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_stall,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_seq_instruction,
  input  logic               i_seq_valid,
  input  logic               i_seq_last,
  input  logic               i_seq_irq,
  input  logic               i_seq_fiq,
  input  logic [INSTR_W-1:0] i_cp_instruction,
  input  logic               i_cp_valid,
  input  logic               i_cp_last,
  output logic               o_seq_ack,
  output logic               o_cp_ack,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_instruction_valid,
  output logic               o_irq,
  output logic               o_fiq,
  output logic               o_owner,
  output logic               o_busy
);

  arb_state_t         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               irq_q, irq_d;
  logic               fiq_q, fiq_d;
  owner_t             owner_q, owner_d;

  logic [1:0] grant;
  owner_t     grant_owner;
  logic       lock;
  owner_t     lock_owner;
  logic       accept;
  logic       beat_last;
  logic       update;

  assign lock       = (state_q != ST_IDLE);
  assign lock_owner = (state_q == ST_LOCK_CP) ? OWNER_CP : OWNER_SEQ;

  zap_rr_arb2 u_arb (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_req          ({i_cp_valid, i_seq_valid}),
    .i_lock         (lock),
    .i_lock_owner   (lock_owner),
    .i_update       (update),
    .i_update_owner (grant_owner),
    .o_grant        (grant),
    .o_grant_owner  (grant_owner)
  );

  // A flush outranks a stall, so neither may let a beat through.
  assign o_seq_ack = grant[0] & ~i_stall & ~i_clear;
  assign o_cp_ack  = grant[1] & ~i_stall & ~i_clear;
  assign accept    = o_seq_ack | o_cp_ack;
  assign beat_last = (grant_owner == OWNER_CP) ? i_cp_last : i_seq_last;
  assign update    = accept & beat_last;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    owner_d = owner_q;
    valid_d = 1'b0;
    irq_d   = 1'b0;
    fiq_d   = 1'b0;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else if (i_stall) begin
      valid_d = valid_q;
      irq_d   = irq_q;
      fiq_d   = fiq_q;
    end else if (accept) begin
      valid_d = 1'b1;
      owner_d = grant_owner;
      instr_d = (grant_owner == OWNER_CP) ? i_cp_instruction : i_seq_instruction;
      // Interrupts ride only on the opening seq beat taken from IDLE.
      if (!lock && grant_owner == OWNER_SEQ) begin
        irq_d = i_seq_irq;
        fiq_d = i_seq_fiq;
      end
      state_d = beat_last ? ST_IDLE : lock_state(grant_owner);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      fiq_q   <= 1'b0;
      owner_q <= OWNER_SEQ;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
      fiq_q   <= fiq_d;
      owner_q <= owner_d;
    end
  end

  assign o_instruction       = instr_q;
  assign o_instruction_valid = valid_q;
  assign o_irq               = irq_q;
  assign o_fiq               = fiq_q;
  assign o_owner             = owner_q;
  assign o_busy              = lock;

endmodule

// File: tb/tb_zap_decode_uop_arbiter.sv
// Scenario bench for zap_decode_uop_arbiter: accepted beats are queued as
// expected output and matched by a monitor when the registered output appears.
module tb_zap_decode_uop_arbiter;

  typedef struct packed {
    logic [34:0] instr;
    logic        owner;
    logic        irq;
    logic        fiq;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n, stall, clear;
  logic [34:0] seq_instr, cp_instr;
  logic        seq_valid, seq_last, seq_irq, seq_fiq;
  logic        cp_valid, cp_last;
  logic        seq_ack, cp_ack;
  logic [34:0] o_instr;
  logic        o_valid, o_irq, o_fiq, o_owner, o_busy;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  logic  mon_en = 1'b0;
  logic  tb_hold = 1'b0;

  always #5 clk = ~clk;

  zap_decode_uop_arbiter dut (
    .i_clk               (clk),
    .i_reset_n           (reset_n),
    .i_stall             (stall),
    .i_clear             (clear),
    .i_seq_instruction   (seq_instr),
    .i_seq_valid         (seq_valid),
    .i_seq_last          (seq_last),
    .i_seq_irq           (seq_irq),
    .i_seq_fiq           (seq_fiq),
    .i_cp_instruction    (cp_instr),
    .i_cp_valid          (cp_valid),
    .i_cp_last           (cp_last),
    .o_seq_ack           (seq_ack),
    .o_cp_ack            (cp_ack),
    .o_instruction       (o_instr),
    .o_instruction_valid (o_valid),
    .o_irq               (o_irq),
    .o_fiq               (o_fiq),
    .o_owner             (o_owner),
    .o_busy              (o_busy)
  );

  // A held (stalled) output is the same beat again, not a new one.
  always @(posedge clk) tb_hold <= reset_n & stall & ~clear;

  always @(negedge clk) begin
    if (mon_en && o_valid && !tb_hold) begin
      beat_t got, exp;
      got = '{instr: o_instr, owner: o_owner, irq: o_irq, fiq: o_fiq};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h with no beat expected", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL out_beat: got instr=%h owner=%b irq=%b fiq=%b expected instr=%h owner=%b irq=%b fiq=%b",
                   got.instr, got.owner, got.irq, got.fiq, exp.instr, exp.owner, exp.irq, exp.fiq);
        end
      end
    end
  end

  function automatic beat_t mk_beat(input logic [34:0] instr, input logic owner,
                                    input logic irq, input logic fiq);
    return '{instr: instr, owner: owner, irq: irq, fiq: fiq};
  endfunction

  // Samples the combinational acks mid-cycle, then advances to just past the edge.
  task automatic tick(output logic sa, output logic ca);
    @(negedge clk);
    sa = seq_ack;
    ca = cp_ack;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; clear = 1'b0;
    seq_instr = '0; seq_valid = 1'b0; seq_last = 1'b0; seq_irq = 1'b0; seq_fiq = 1'b0;
    cp_instr = '0; cp_valid = 1'b0; cp_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_instr, o_valid, o_irq, o_fiq, o_owner, o_busy} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got instr=%h v=%b irq=%b fiq=%b own=%b busy=%b required all 0",
               o_instr, o_valid, o_irq, o_fiq, o_owner, o_busy);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_round_robin();
    logic sa, ca;
    seq_valid = 1'b1; seq_last = 1'b1; seq_instr = 35'h1_0000_0A01;
    cp_valid  = 1'b1; cp_last  = 1'b1; cp_instr  = 35'h2_0000_0B01;
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b10) begin
      errors++; $display("FAIL rr_first_seq: got seq_ack=%b cp_ack=%b required 1 0", sa, ca);
    end
    sb.push_back(mk_beat(seq_instr, 1'b0, 1'b0, 1'b0));
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b01) begin
      errors++; $display("FAIL rr_second_cp: got seq_ack=%b cp_ack=%b required 0 1", sa, ca);
    end
    sb.push_back(mk_beat(cp_instr, 1'b1, 1'b0, 1'b0));
    seq_valid = 1'b0; cp_valid = 1'b0;
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b00) begin
      errors++; $display("FAIL rr_idle_acks: got seq_ack=%b cp_ack=%b required 0 0", sa, ca);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL rr_idle_valid: got %b required 0", o_valid);
    end
  endtask

  task automatic test_lock_seq();
    logic sa, ca;
    int   busy_cnt = 0;
    cp_valid = 1'b1; cp_last = 1'b1; cp_instr = 35'h2_0000_0C05;
    seq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seq_instr = 35'h0_1000_0000 + 35'(i);
      seq_last  = (i == 3);
      tick(sa, ca);
      checks++;
      if ({sa, ca} !== 2'b10) begin
        errors++; $display("FAIL lock_beat%0d_acks: got seq_ack=%b cp_ack=%b required 1 0", i, sa, ca);
      end
      sb.push_back(mk_beat(seq_instr, 1'b0, 1'b0, 1'b0));
      if (o_busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 3) begin
      errors++; $display("FAIL lock_busy_cycles: got %0d required 3", busy_cnt);
    end
    // The seq interrupt line must not leak onto a cp beat.
    seq_valid = 1'b0; seq_irq = 1'b1;
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b01) begin
      errors++; $display("FAIL lock_cp_after: got seq_ack=%b cp_ack=%b required 0 1", sa, ca);
    end
    sb.push_back(mk_beat(cp_instr, 1'b1, 1'b0, 1'b0));
    cp_valid = 1'b0; seq_irq = 1'b0;
    tick(sa, ca);
  endtask

  task automatic test_irq();
    logic sa, ca;
    seq_valid = 1'b1; seq_irq = 1'b1; seq_fiq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seq_instr = 35'h3_0000_0100 + 35'(i);
      seq_last  = (i == 2);
      tick(sa, ca);
      checks++;
      if (sa !== 1'b1) begin
        errors++; $display("FAIL irq_beat%0d_ack: got %b required 1", i, sa);
      end
      sb.push_back(mk_beat(seq_instr, 1'b0, i == 0, i == 0));
    end
    seq_valid = 1'b0; seq_irq = 1'b0; seq_fiq = 1'b0;
    tick(sa, ca);
  endtask

  task automatic test_stall();
    logic sa, ca;
    seq_valid = 1'b1; seq_last = 1'b0; seq_instr = 35'h4_0000_00D0;
    tick(sa, ca);
    sb.push_back(mk_beat(seq_instr, 1'b0, 1'b0, 1'b0));
    seq_instr = 35'h4_0000_00D1; stall = 1'b1; cp_valid = 1'b1; cp_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(sa, ca);
      checks++;
      if ({sa, ca} !== 2'b00) begin
        errors++; $display("FAIL stall%0d_acks: got seq_ack=%b cp_ack=%b required 0 0", i, sa, ca);
      end
      checks++;
      if ({o_instr, o_valid, o_busy} !== {35'h4_0000_00D0, 1'b1, 1'b1}) begin
        errors++; $display("FAIL stall%0d_frozen: got instr=%h v=%b busy=%b required 4000000d0 1 1",
                           i, o_instr, o_valid, o_busy);
      end
    end
    stall = 1'b0;
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b10) begin
      errors++; $display("FAIL stall_resume: got seq_ack=%b cp_ack=%b required 1 0", sa, ca);
    end
    sb.push_back(mk_beat(seq_instr, 1'b0, 1'b0, 1'b0));
    cp_valid = 1'b0; seq_instr = 35'h4_0000_00D2; seq_last = 1'b1;
    tick(sa, ca);
    sb.push_back(mk_beat(seq_instr, 1'b0, 1'b0, 1'b0));
    seq_valid = 1'b0;
    tick(sa, ca);
  endtask

  task automatic test_clear_lock_cp();
    logic sa, ca;
    cp_valid = 1'b1; cp_last = 1'b0; cp_instr = 35'h5_0000_00E0;
    tick(sa, ca);
    sb.push_back(mk_beat(cp_instr, 1'b1, 1'b0, 1'b0));
    cp_valid = 1'b0; seq_valid = 1'b1; seq_last = 1'b1; seq_instr = 35'h5_0000_0F00;
    tick(sa, ca);
    checks++;
    if ({sa, ca, o_busy, o_valid} !== 4'b0010) begin
      errors++; $display("FAIL lockcp_gap: got seq_ack=%b cp_ack=%b busy=%b v=%b required 0 0 1 0",
                         sa, ca, o_busy, o_valid);
    end
    cp_valid = 1'b1; cp_instr = 35'h5_0000_00E1; clear = 1'b1; stall = 1'b1;
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b00) begin
      errors++; $display("FAIL clear_acks: got seq_ack=%b cp_ack=%b required 0 0", sa, ca);
    end
    checks++;
    if ({o_valid, o_busy, o_irq, o_fiq} !== 4'b0000) begin
      errors++; $display("FAIL clear_state: got v=%b busy=%b irq=%b fiq=%b required 0 0 0 0",
                         o_valid, o_busy, o_irq, o_fiq);
    end
    // Pointer still favours cp after the flush.
    clear = 1'b0; stall = 1'b0; cp_last = 1'b1; cp_instr = 35'h5_0000_00E2;
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b01) begin
      errors++; $display("FAIL clear_ptr_kept: got seq_ack=%b cp_ack=%b required 0 1", sa, ca);
    end
    sb.push_back(mk_beat(cp_instr, 1'b1, 1'b0, 1'b0));
    cp_valid = 1'b0;
    tick(sa, ca);
    sb.push_back(mk_beat(seq_instr, 1'b0, 1'b0, 1'b0));
    seq_valid = 1'b0;
    tick(sa, ca);
  endtask

  task automatic test_reset_lock();
    logic sa, ca;
    seq_valid = 1'b1; seq_last = 1'b0; seq_instr = 35'h6_0000_0F0F;
    tick(sa, ca);
    sb.push_back(mk_beat(seq_instr, 1'b0, 1'b0, 1'b0));
    reset_n = 1'b0; stall = 1'b1; clear = 1'b1;
    tick(sa, ca);
    checks++;
    if ({o_instr, o_valid, o_irq, o_fiq, o_owner, o_busy} !== 40'd0) begin
      errors++;
      $display("FAIL reset_in_lock: got instr=%h v=%b irq=%b fiq=%b own=%b busy=%b required all 0",
               o_instr, o_valid, o_irq, o_fiq, o_owner, o_busy);
    end
    reset_n = 1'b1; stall = 1'b0; clear = 1'b0;
    seq_last = 1'b1; seq_instr = 35'h6_0000_0A0A;
    cp_valid = 1'b1; cp_last = 1'b1; cp_instr = 35'h6_0000_0B0B;
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b10) begin
      errors++; $display("FAIL reset_ptr_seq: got seq_ack=%b cp_ack=%b required 1 0", sa, ca);
    end
    sb.push_back(mk_beat(seq_instr, 1'b0, 1'b0, 1'b0));
    tick(sa, ca);
    checks++;
    if ({sa, ca} !== 2'b01) begin
      errors++; $display("FAIL reset_then_cp: got seq_ack=%b cp_ack=%b required 0 1", sa, ca);
    end
    sb.push_back(mk_beat(cp_instr, 1'b1, 1'b0, 1'b0));
    seq_valid = 1'b0; cp_valid = 1'b0;
    repeat (2) tick(sa, ca);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock_seq();
    test_irq();
    test_stall();
    test_clear_lock_cp();
    test_reset_lock();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d beats never output required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zap_decode_uop_arbiter.md
ZAP_DECODE_UOP_ARBITER -- requirements
Module: zap_decode_uop_arbiter

Interface
REQ-001 SHALL have one clock: i_clk, input, 1, clock for all state, rising edge.
REQ-002 SHALL have one reset: i_reset_n, input, 1, synchronous and active-low.
REQ-003 SHALL have i_stall, input, 1: OR of data, shifter and issue stalls; hold everything when high.
REQ-004 SHALL have i_clear, input, 1: flush from ALU or writeback.
REQ-005 SHALL have requester 0 (LDM/STM/SWP sequencer): i_seq_instruction [34:0], i_seq_valid 1, i_seq_last 1, i_seq_irq 1, i_seq_fiq 1.
REQ-006 SHALL have requester 1 (coprocessor micro-op source): i_cp_instruction [34:0], i_cp_valid 1, i_cp_last 1.
REQ-007 SHALL have o_seq_ack and o_cp_ack, output, 1 each: the beat is accepted this cycle.
REQ-008 SHALL have o_instruction [34:0], o_instruction_valid 1, o_irq 1, o_fiq 1, o_owner 1 (0=seq, 1=cp), o_busy 1 (a lock is held).

Function
REQ-009 SHALL implement states IDLE, LOCK_SEQ and LOCK_CP.
REQ-010 In IDLE, a single valid requester SHALL be granted.
REQ-011 In IDLE, if both requesters are valid, the round-robin pointer SHALL pick the winner; pointer reset value is 0 (seq first).
REQ-012 SHALL accept a beat (ack=1) only when it is granted and i_stall=0; acks are combinational and one-hot at most.
REQ-013 An accepted beat with last=0 SHALL move the FSM to LOCK_<owner>.
REQ-014 An accepted beat with last=1 SHALL leave the FSM in (or return it to) IDLE and set the pointer to the other requester.
REQ-015 In LOCK_x, only requester x SHALL be granted; the other requester's valid is ignored regardless of priority.
REQ-016 In LOCK_x with requester x invalid, the FSM SHALL hold LOCK_x and drive o_instruction_valid=0 next cycle.
REQ-017 Outputs SHALL be registered with 1-cycle latency: a beat accepted at edge N appears on o_instruction* after edge N, with o_owner = grantee.
REQ-018 o_irq/o_fiq SHALL reflect i_seq_irq/i_seq_fiq only on the first beat of a seq sequence accepted in IDLE; they SHALL be 0 on locked beats and on all cp beats.
REQ-019 With i_stall=1, all registers SHALL hold and both acks SHALL be 0.
REQ-020 With i_clear=1, next state SHALL be o_instruction_valid=0, o_irq=o_fiq=0, FSM=IDLE, pointer unchanged, acks 0.
REQ-021 If i_clear and i_stall are both high, i_clear SHALL win.
REQ-022 When no beat is accepted and there is no stall, o_instruction_valid SHALL be 0 next cycle; o_instruction may hold its old value.
REQ-023 o_busy SHALL be high exactly in LOCK_SEQ and LOCK_CP.

Reset
REQ-024 With i_reset_n=0 at a clock edge, the block SHALL go to IDLE with pointer=0, o_instruction=0, o_instruction_valid=0, o_irq=0, o_fiq=0, o_owner=0.
REQ-025 Reset SHALL take priority over i_clear and i_stall.
REQ-026 Reset during a lock SHALL drop the lock; no partial sequence resumes.

Structure
REQ-027 State encodings (IDLE=0, LOCK_SEQ=1, LOCK_CP=2) and owner IDs SHALL live in the shared decode constants header/package.
REQ-028 Grant/pointer logic SHALL be one sub-module, zap_rr_arb2: 2-way round-robin with a lock input. The FSM and output register stay in the top.

Verification
REQ-029 Both requesters valid after reset, single-beat (last=1) each, no stall -> seq acked cycle 1, cp acked cycle 2, o_owner 0 then 1.
REQ-030 Seq issues a 4-beat sequence (last on beat 4) while cp stays valid -> cp_ack=0 for 4 cycles, o_busy=1 for 3 cycles, cp granted on cycle 5.
REQ-031 i_seq_irq=1 across a 3-beat seq sequence -> o_irq=1 only with beat 1 and 0 with beats 2-3.
REQ-032 i_stall=1 for 2 cycles mid-lock -> outputs frozen, no acks, sequence resumes with the next beat and no loss or duplicate.
REQ-033 i_clear asserted together with i_stall during LOCK_CP -> next cycle IDLE, o_instruction_valid=0, o_busy=0.
REQ-034 i_reset_n=0 for one edge during LOCK_SEQ -> all outputs 0, pointer=0, and a subsequent simultaneous request grants seq.
